ttt_move_input: RTL and testbench

//  Upstream input stage for the tic-tac-toe game core (tttg). Conditions the nine raw cell push-buttons

---
 rtl/ttt_pkg.sv | 18 +
 rtl/ttt_debounce.sv | 48 ++++
 rtl/ttt_move_input.sv | 123 ++++++++++++
 tb/tb_ttt_move_input.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and helpers for the tic-tac-toe move input stage.
package ttt_pkg;

    localparam int unsigned N_CELLS = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        WAIT_PC = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // True when exactly one bit of the cell vector is set.
    function automatic logic is_onehot(input logic [N_CELLS-1:0] v);
        return (v != '0) && ((v & (v - N_CELLS'(1))) == '0);
    endfunction

endpackage

// File: rtl/ttt_debounce.sv
// One cell button: 2-flop synchroniser followed by a stability-count debouncer.
module ttt_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic db
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounced level follows the synchronised level once it has differed long enough.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/ttt_move_input.sv
// Turns raw cell buttons into a one-hot move with a play strobe, then times
// the pc strobe that asks the game core for the computer's move.
module ttt_move_input
    import ttt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PC_DELAY        = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CELLS-1:0] btn_raw,
    input  logic               pc_en,
    output logic               play,
    output logic               pc,
    output logic [N_CELLS-1:0] button,
    output logic               busy,
    output logic               err_multi
);

    logic [N_CELLS-1:0] db;

    for (genvar i = 0; i < int'(N_CELLS); i++) begin : g_cell
        ttt_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .btn_raw(btn_raw[i]),
            .db     (db[i])
        );
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   dly_q, dly_d;
    logic [N_CELLS-1:0] db_prev_q, db_prev_d;
    logic [N_CELLS-1:0] button_q, button_d;
    logic               play_q, play_d;
    logic               pc_q, pc_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    // Move sequencing; the delay counter is loaded so pc lands PC_DELAY cycles after play.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        db_prev_d = db;
        button_d  = button_q;
        play_d    = 1'b0;
        pc_d      = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (db != '0 && db_prev_q == '0) begin
                    if (is_onehot(db)) begin
                        button_d = db;
                        play_d   = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            HOLD: begin
                if (!pc_en) begin
                    state_d = RELEASE;
                end else if (PC_DELAY <= 1) begin
                    pc_d    = 1'b1;
                    state_d = RELEASE;
                end else begin
                    dly_d   = CNT_W'(PC_DELAY - 1);
                    state_d = WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (dly_q <= CNT_W'(1)) begin
                    pc_d    = 1'b1;
                    state_d = RELEASE;
                end else begin
                    dly_d = dly_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                if (db == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dly_q     <= '0;
            db_prev_q <= '0;
            button_q  <= '0;
            play_q    <= 1'b0;
            pc_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            db_prev_q <= db_prev_d;
            button_q  <= button_d;
            play_q    <= play_d;
            pc_q      <= pc_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign play      = play_q;
    assign pc        = pc_q;
    assign button    = button_q;
    assign busy      = busy_q;
    assign err_multi = err_q;

endmodule

// File: tb/tb_ttt_move_input.sv
// Scoreboard bench for ttt_move_input: stimulus queues expected strobes, a monitor checks them.
module tb_ttt_move_input;

    localparam int K_PLAY = 0;
    localparam int K_PC   = 1;
    localparam int K_ERR  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] btn_raw = '0;
    logic       pc_en = 1'b0;
    logic       play, pc, busy, err_multi;
    logic [8:0] button;

    ttt_move_input #(
        .DEBOUNCE_CYCLES(4),
        .PC_DELAY       (8),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .pc_en    (pc_en),
        .play     (play),
        .pc       (pc),
        .button   (button),
        .busy     (busy),
        .err_multi(err_multi)
    );

    always #1 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         kind;
        int         cyc;
        logic [8:0] btn;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int c, input logic [8:0] b);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.btn  = b;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            check("strobe_kind", 32'(kind), 32'(e.kind));
            check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            check("strobe_button", 32'(button), 32'(e.btn));
        end
    endtask

    // Monitor: every strobe the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        if (play && pc) check("play_pc_overlap", 32'(1), 32'(0));
        if (play)      take(K_PLAY);
        if (pc)        take(K_PC);
        if (err_multi) take(K_ERR);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new raw value; k is the edge that first samples it.
    task automatic set_raw(input logic [8:0] v, output int k);
        @(negedge clk);
        btn_raw = v;
        k = cyc + 1;
    endtask

    initial begin
        int k, k2;

        // 1: reset with all buttons held, then a rejected multi-press
        reset   = 1'b1;
        btn_raw = 9'h1FF;
        tick(10);
        check("rst_play", 32'(play), 32'(0));
        check("rst_pc", 32'(pc), 32'(0));
        check("rst_button", 32'(button), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_err", 32'(err_multi), 32'(0));
        reset = 1'b0;
        k = cyc + 1;
        expect_ev(K_ERR, k + 7, 9'h000);
        tick(20);
        check("t1_busy_held", 32'(busy), 32'(1));
        set_raw(9'h000, k2);
        tick(12);
        check("t1_busy_released", 32'(busy), 32'(0));

        // 2: single press with computer move
        pc_en = 1'b1;
        set_raw(9'h100, k);
        expect_ev(K_PLAY, k + 7, 9'h100);
        expect_ev(K_PC, k + 15, 9'h100);
        tick(20);
        check("t2_busy_held", 32'(busy), 32'(1));
        set_raw(9'h000, k2);
        tick(12);
        check("t2_busy_released", 32'(busy), 32'(0));

        // 3: bouncing press settles to one move
        for (int i = 0; i < 5; i++) begin
            set_raw((i % 2 == 0) ? 9'h004 : 9'h000, k);
        end
        expect_ev(K_PLAY, k + 7, 9'h004);
        expect_ev(K_PC, k + 15, 9'h004);
        tick(20);
        set_raw(9'h000, k2);
        tick(12);
        check("t3_button", 32'(button), 32'(9'h004));

        // 4: two buttons together are rejected, button keeps last move
        set_raw(9'h011, k);
        expect_ev(K_ERR, k + 7, 9'h004);
        tick(15);
        set_raw(9'h000, k2);
        tick(12);
        check("t4_button_kept", 32'(button), 32'(9'h004));
        check("t4_busy", 32'(busy), 32'(0));

        // 5: player-vs-player, second button during hold is ignored
        pc_en = 1'b0;
        set_raw(9'h001, k);
        expect_ev(K_PLAY, k + 7, 9'h001);
        tick(10);
        set_raw(9'h003, k2);
        tick(10);
        set_raw(9'h000, k2);
        tick(25);
        check("t5_button", 32'(button), 32'(9'h001));
        check("t5_busy", 32'(busy), 32'(0));

        // 6: reset three cycles into the pc wait cancels the move
        pc_en = 1'b1;
        set_raw(9'h080, k);
        expect_ev(K_PLAY, k + 7, 9'h080);
        tick(11);
        reset   = 1'b1;
        btn_raw = 9'h000;
        tick(3);
        reset = 1'b0;
        tick(25);
        check("t6_button", 32'(button), 32'(0));
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_pc", 32'(pc), 32'(0));

        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
